pkt_test_scheduler: RTL and testbench

PKT_TEST_SCHEDULER -- requirements
Module: pkt_test_scheduler

---
 rtl/pkt_test_scheduler.sv | 172 +++++++++++++++++
 tb/tb_pkt_test_scheduler.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_test_scheduler.sv
// Packet test-suite scheduler: runs num_test tests of n_pkt packets each and offers
// LFSR-derived packet lengths to a dummy-model driver over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | latch packet target for the current test, clear pkt_idx
// SEND  | offer descriptors until target handshakes have completed
// GAP   | one-cycle pause between tests, flags test_done
// DONE  | suite complete, flags suite_done
module pkt_test_scheduler #(
  parameter int          NUM_TEST_W = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_TEST_W-1:0] num_test,
  input  logic [8:0]            n_pkt,
  input  logic                  small_len,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [7:0]            pkt_len,
  output logic                  test_start,
  output logic                  test_done,
  output logic                  suite_done,
  output logic                  aborted,
  output logic                  busy,
  output logic [NUM_TEST_W-1:0] test_idx,
  output logic [8:0]            pkt_idx
);

  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [7:0] len_of(input logic [15:0] s, input logic sm);
    logic [7:0] l;
    if (sm) begin
      l = {5'b00000, s[2:0]} + 8'd1;
    end else begin
      l = (s[7:0] == 8'd0) ? 8'd1 : s[7:0];
    end
    return l;
  endfunction

  function automatic logic [8:0] clamp_target(input logic [8:0] n);
    logic [8:0] t;
    if (n == 9'd0) begin
      t = 9'd1;
    end else if (n > 9'd256) begin
      t = 9'd256;
    end else begin
      t = n;
    end
    return t;
  endfunction

  state_t                state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [NUM_TEST_W-1:0] num_test_q, num_test_d, test_idx_d;
  logic                  small_len_q, small_len_d;
  logic [8:0]            target_q, target_d, pkt_idx_d;
  logic [NUM_TEST_W:0]   test_idx_inc;
  logic                  start_ok, abort_ok, hs, last_pkt, more_tests;
  logic                  pkt_valid_d, busy_d, test_start_d, test_done_d;
  logic                  suite_done_d, aborted_d;
  logic [7:0]            pkt_len_d;

  assign start_ok     = (state_q == S_IDLE) && start;
  assign abort_ok     = (state_q != S_IDLE) && abort;
  assign hs           = pkt_valid && pkt_ready;
  assign last_pkt     = hs && ((pkt_idx + 9'd1) == target_q);
  assign test_idx_inc = {1'b0, test_idx} + {{NUM_TEST_W{1'b0}}, 1'b1};
  assign more_tests   = test_idx_inc < {1'b0, num_test_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_test == '0) ? S_DONE : S_LOAD;
      S_LOAD:  state_d = S_SEND;
      S_SEND:  if (last_pkt) state_d = S_GAP;
      S_GAP:   state_d = more_tests ? S_LOAD : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_ok) state_d = S_IDLE;
  end

  // Handshakes count even on an abort cycle; status pulses trail their state by one
  // cycle and are suppressed when that state is left through an abort.
  always_comb begin
    lfsr_d      = hs ? lfsr_step(lfsr_q) : lfsr_q;
    pkt_idx_d   = hs ? (pkt_idx + 9'd1) : pkt_idx;
    num_test_d  = num_test_q;
    small_len_d = small_len_q;
    target_d    = target_q;
    test_idx_d  = test_idx;
    if (start_ok) begin
      num_test_d  = num_test;
      small_len_d = small_len;
      test_idx_d  = '0;
      pkt_idx_d   = '0;
    end
    if (state_q == S_LOAD) begin
      target_d  = clamp_target(n_pkt);
      pkt_idx_d = '0;
    end
    if ((state_q == S_GAP) && (state_d == S_LOAD)) begin
      test_idx_d = test_idx_inc[NUM_TEST_W-1:0];
    end
    pkt_valid_d  = (state_d == S_SEND);
    busy_d       = (state_d != S_IDLE);
    test_start_d = (state_q == S_LOAD) && !abort_ok;
    test_done_d  = (state_q == S_GAP)  && !abort_ok;
    suite_done_d = (state_q == S_DONE) && !abort_ok;
    aborted_d    = abort_ok;
    pkt_len_d    = pkt_valid_d ? len_of(lfsr_d, small_len_d) : pkt_len;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q      <= SEED;
      num_test_q  <= '0;
      small_len_q <= 1'b0;
      target_q    <= '0;
      test_idx    <= '0;
      pkt_idx     <= '0;
      pkt_valid   <= 1'b0;
      pkt_len     <= '0;
      busy        <= 1'b0;
      test_start  <= 1'b0;
      test_done   <= 1'b0;
      suite_done  <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      num_test_q  <= num_test_d;
      small_len_q <= small_len_d;
      target_q    <= target_d;
      test_idx    <= test_idx_d;
      pkt_idx     <= pkt_idx_d;
      pkt_valid   <= pkt_valid_d;
      pkt_len     <= pkt_len_d;
      busy        <= busy_d;
      test_start  <= test_start_d;
      test_done   <= test_done_d;
      suite_done  <= suite_done_d;
      aborted     <= aborted_d;
    end
  end

endmodule

// File: tb/tb_pkt_test_scheduler.sv
// Self-checking bench for pkt_test_scheduler: expected packet lengths come from a
// reference LFSR and are queued at start, then popped at each observed handshake.
module tb_pkt_test_scheduler;
  localparam int NTW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           small_len = 1'b0;
  logic           pkt_ready = 1'b0;
  logic [NTW-1:0] num_test = '0;
  logic [8:0]     n_pkt = '0;
  logic           pkt_valid, test_start, test_done, suite_done, aborted, busy;
  logic [7:0]     pkt_len;
  logic [NTW-1:0] test_idx;
  logic [8:0]     pkt_idx;

  int          n_run = 0;
  int          n_fail = 0;
  logic [15:0] ref_lfsr = 16'hACE1;
  logic [7:0]  exp_q[$];

  pkt_test_scheduler #(.NUM_TEST_W(NTW), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_test(num_test),
    .n_pkt(n_pkt), .small_len(small_len), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_len(pkt_len), .test_start(test_start), .test_done(test_done),
    .suite_done(suite_done), .aborted(aborted), .busy(busy), .test_idx(test_idx),
    .pkt_idx(pkt_idx)
  );

  always #5 clk = ~clk;

  // Taps x^16, x^14, x^13, x^11 -> bits 15, 13, 12, 10; shift left, feedback into bit 0.
  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic logic [7:0] ref_len(input logic [15:0] s, input logic sm);
    int v;
    v = sm ? (int'(s[2:0]) + 1) : int'(s[7:0]);
    if (v == 0) v = 1;
    return 8'(v);
  endfunction

  task automatic push_exp(input int n, input logic sm);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ref_len(ref_lfsr, sm));
      ref_lfsr = ref_step(ref_lfsr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_run++;
    if ({pkt_valid, busy, test_start, test_done, suite_done, aborted} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000",
                         {pkt_valid, busy, test_start, test_done, suite_done, aborted});
    end
    n_run++;
    if (pkt_len !== 8'd0) begin n_fail++; $display("FAIL reset_len: got %0d expected 0", pkt_len); end
    n_run++;
    if (test_idx !== '0 || pkt_idx !== '0) begin
      n_fail++; $display("FAIL reset_idx: got %0d/%0d expected 0/0", test_idx, pkt_idx);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_lfsr = 16'hACE1;
    @(negedge clk);
    n_run++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_random_stall();
    int n_td = 0;
    bit sd = 0, prev_stall = 0;
    logic [7:0] prev_len = '0, e;
    exp_q.delete();
    @(negedge clk);
    num_test = 2; n_pkt = 20; small_len = 1'b1; pkt_ready = 1'b0; start = 1'b1;
    push_exp(40, 1'b1);
    for (int c = 0; c < 400 && !sd; c++) begin
      @(negedge clk);
      if (prev_stall && pkt_valid) begin
        n_run++;
        if (pkt_len !== prev_len) begin
          n_fail++; $display("FAIL stall_len_stable: got %0d expected %0d", pkt_len, prev_len);
        end
      end
      if (pkt_valid) begin
        n_run++;
        if (pkt_len < 8'd1 || pkt_len > 8'd8) begin
          n_fail++; $display("FAIL small_len_range: got %0d expected 1..8", pkt_len);
        end
      end
      start = (c == 10);
      if (c == 10) num_test = 5;
      pkt_ready = 1'($urandom_range(0, 1));
      if (pkt_valid && pkt_ready) begin
        n_run++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stall_len: unexpected handshake len %0d", pkt_len);
        end else begin
          e = exp_q.pop_front();
          if (pkt_len !== e) begin n_fail++; $display("FAIL stall_len: got %0d expected %0d", pkt_len, e); end
        end
      end
      prev_stall = pkt_valid && !pkt_ready;
      prev_len = pkt_len;
      if (test_done) n_td++;
      if (suite_done) sd = 1;
    end
    start = 1'b0;
    n_run++;
    if (!sd) begin n_fail++; $display("FAIL stall_timeout: suite_done 0 expected 1"); end
    n_run++;
    if (n_td != 2) begin n_fail++; $display("FAIL stall_test_done_count: got %0d expected 2", n_td); end
    n_run++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_missing_hs: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_basic_suite();
    int n_ts = 0, n_td = 0, n_sd = 0, n_hs = 0, n_busy = 0;
    logic [7:0] e;
    exp_q.delete();
    @(negedge clk);
    num_test = 3; n_pkt = 5; small_len = 1'b0; pkt_ready = 1'b1; start = 1'b1;
    push_exp(15, 1'b0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) n_busy++;
      if (test_start) n_ts++;
      if (suite_done) n_sd++;
      if (test_done) begin
        n_td++;
        n_run++;
        if (pkt_idx !== 9'd5) begin n_fail++; $display("FAIL basic_pkt_idx_at_done: got %0d expected 5", pkt_idx); end
      end
      if (pkt_valid && pkt_ready) begin
        n_hs++;
        n_run++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL basic_len: unexpected handshake len %0d", pkt_len);
        end else begin
          e = exp_q.pop_front();
          if (pkt_len !== e) begin n_fail++; $display("FAIL basic_len: got %0d expected %0d", pkt_len, e); end
        end
      end
    end
    n_run++;
    if (n_ts != 3) begin n_fail++; $display("FAIL basic_test_start: got %0d expected 3", n_ts); end
    n_run++;
    if (n_td != 3) begin n_fail++; $display("FAIL basic_test_done: got %0d expected 3", n_td); end
    n_run++;
    if (n_sd != 1) begin n_fail++; $display("FAIL basic_suite_done: got %0d expected 1", n_sd); end
    n_run++;
    if (n_hs != 15) begin n_fail++; $display("FAIL basic_handshakes: got %0d expected 15", n_hs); end
    n_run++;
    if (n_busy != 22) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 22", n_busy); end
    n_run++;
    if (test_idx !== 8'd2 || pkt_idx !== 9'd5) begin
      n_fail++; $display("FAIL basic_final_idx: got %0d/%0d expected 2/5", test_idx, pkt_idx);
    end
  endtask

  task automatic test_zero_tests();
    int first_sd = -1, n_sd = 0, n_busy = 0;
    bit saw_valid = 0;
    @(negedge clk);
    num_test = 0; n_pkt = 5; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (pkt_valid) saw_valid = 1;
      if (busy) n_busy++;
      if (suite_done) begin n_sd++; if (first_sd < 0) first_sd = c; end
    end
    n_run++;
    if (first_sd != 2) begin n_fail++; $display("FAIL zero_suite_done_cycle: got %0d expected 2", first_sd); end
    n_run++;
    if (n_sd != 1) begin n_fail++; $display("FAIL zero_suite_done_count: got %0d expected 1", n_sd); end
    n_run++;
    if (saw_valid) begin n_fail++; $display("FAIL zero_pkt_valid: got 1 expected 0"); end
    n_run++;
    if (n_busy != 1) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d expected 1", n_busy); end
    n_run++;
    if (test_idx !== '0) begin n_fail++; $display("FAIL zero_test_idx_cleared: got %0d expected 0", test_idx); end
  endtask

  task automatic test_clamp();
    int hs0 = 0, hs1 = 0, n_td = 0;
    bit sd = 0;
    logic [7:0] e;
    exp_q.delete();
    @(negedge clk);
    num_test = 2; n_pkt = 9'd0; small_len = 1'b0; pkt_ready = 1'b1; start = 1'b1;
    push_exp(257, 1'b0);
    for (int c = 0; c < 320 && !sd; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (test_done) begin
        n_run++;
        if (pkt_idx !== ((n_td == 0) ? 9'd1 : 9'd256)) begin
          n_fail++; $display("FAIL clamp_pkt_idx_at_done: got %0d expected %0d", pkt_idx, (n_td == 0) ? 1 : 256);
        end
        n_td++;
      end
      if (pkt_valid && pkt_ready) begin
        if (test_idx == 0) hs0++; else hs1++;
        n_run++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL clamp_len: unexpected handshake len %0d", pkt_len);
        end else begin
          e = exp_q.pop_front();
          if (pkt_len !== e) begin n_fail++; $display("FAIL clamp_len: got %0d expected %0d", pkt_len, e); end
        end
        n_pkt = 9'd300;
      end
      if (suite_done) sd = 1;
    end
    n_run++;
    if (!sd) begin n_fail++; $display("FAIL clamp_timeout: suite_done 0 expected 1"); end
    n_run++;
    if (hs0 != 1) begin n_fail++; $display("FAIL clamp_zero_to_one: got %0d expected 1", hs0); end
    n_run++;
    if (hs1 != 256) begin n_fail++; $display("FAIL clamp_300_to_256: got %0d expected 256", hs1); end
  endtask

  task automatic test_start_abort_idle();
    int n_ab = 0, n_hs = 0;
    bit sd = 0;
    logic [7:0] e;
    exp_q.delete();
    @(negedge clk);
    num_test = 1; n_pkt = 9'd1; small_len = 1'b0; pkt_ready = 1'b1; start = 1'b1; abort = 1'b1;
    push_exp(1, 1'b0);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_run++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL idle_abort_start: busy %b expected 1", busy); end
    for (int c = 0; c < 10 && !sd; c++) begin
      @(negedge clk);
      if (aborted) n_ab++;
      if (pkt_valid && pkt_ready) begin
        n_hs++;
        n_run++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL idle_abort_len: unexpected handshake len %0d", pkt_len);
        end else begin
          e = exp_q.pop_front();
          if (pkt_len !== e) begin n_fail++; $display("FAIL idle_abort_len: got %0d expected %0d", pkt_len, e); end
        end
      end
      if (suite_done) sd = 1;
    end
    n_run++;
    if (!sd || n_ab != 0 || n_hs != 1) begin
      n_fail++; $display("FAIL idle_abort_suite: sd %0d aborted %0d hs %0d expected 1 0 1", sd, n_ab, n_hs);
    end
  endtask

  task automatic test_abort();
    int post = 0;
    bit ab_done = 0, sd = 0;
    logic [7:0] e;
    exp_q.delete();
    @(negedge clk);
    num_test = 3; n_pkt = 9'd4; small_len = 1'b0; pkt_ready = 1'b1; start = 1'b1;
    push_exp(7, 1'b0);
    for (int c = 0; c < 60 && post < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (ab_done) begin
        post++;
        if (post == 1) begin
          n_run++;
          if (pkt_valid !== 1'b0 || aborted !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_next_cycle: valid/aborted/busy %b%b%b expected 010", pkt_valid, aborted, busy);
          end
        end else begin
          n_run++;
          if (aborted !== 1'b0) begin n_fail++; $display("FAIL abort_pulse_width: got 1 expected 0"); end
        end
        n_run++;
        if (test_done !== 1'b0 || suite_done !== 1'b0) begin
          n_fail++; $display("FAIL abort_no_status: done/suite %b%b expected 00", test_done, suite_done);
        end
      end
      abort = 1'b0;
      if (!ab_done && pkt_valid && test_idx == 1 && pkt_idx == 2) begin
        abort = 1'b1;
        ab_done = 1;
      end
      if (pkt_valid && pkt_ready) begin
        n_run++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL abort_len: unexpected handshake len %0d", pkt_len);
        end else begin
          e = exp_q.pop_front();
          if (pkt_len !== e) begin n_fail++; $display("FAIL abort_len: got %0d expected %0d", pkt_len, e); end
        end
      end
    end
    abort = 1'b0;
    n_run++;
    if (!ab_done) begin n_fail++; $display("FAIL abort_timeout: abort point 0 expected 1"); end
    n_run++;
    if (pkt_idx !== 9'd3 || test_idx !== 8'd1) begin
      n_fail++; $display("FAIL abort_final_idx: got %0d/%0d expected 1/3", test_idx, pkt_idx);
    end
    // A follow-on suite shows the LFSR carried on from the aborted run.
    exp_q.delete();
    @(negedge clk);
    num_test = 1; n_pkt = 9'd2; start = 1'b1;
    push_exp(2, 1'b0);
    for (int c = 0; c < 12 && !sd; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (pkt_valid && pkt_ready) begin
        n_run++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL continue_len: unexpected handshake len %0d", pkt_len);
        end else begin
          e = exp_q.pop_front();
          if (pkt_len !== e) begin n_fail++; $display("FAIL continue_len: got %0d expected %0d", pkt_len, e); end
        end
      end
      if (suite_done) sd = 1;
    end
    n_run++;
    if (!sd || exp_q.size() != 0) begin
      n_fail++; $display("FAIL continue_suite: sd %0d left %0d expected 1 0", sd, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_send();
    int n_hs = 0, n_td = 0, n_pulse = 0;
    bit sd = 0;
    logic [7:0] e;
    exp_q.delete();
    @(negedge clk);
    num_test = 2; n_pkt = 9'd10; small_len = 1'b0; pkt_ready = 1'b1; start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_run++;
    if (pkt_valid !== 1'b1) begin n_fail++; $display("FAIL rst_send_precond: valid %b expected 1", pkt_valid); end
    #2 rst = 1'b1;
    #1;
    n_run++;
    if ({pkt_valid, busy, test_start, test_done, suite_done, aborted} !== 6'b0) begin
      n_fail++; $display("FAIL rst_async_flags: got %b expected 000000",
                         {pkt_valid, busy, test_start, test_done, suite_done, aborted});
    end
    n_run++;
    if (pkt_len !== 8'd0 || pkt_idx !== 9'd0 || test_idx !== '0) begin
      n_fail++; $display("FAIL rst_async_values: len %0d pkt %0d test %0d expected 0 0 0", pkt_len, pkt_idx, test_idx);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    n_run++;
    if ({test_done, suite_done, aborted} !== 3'b0) begin
      n_fail++; $display("FAIL rst_hold_pulses: got %b expected 000", {test_done, suite_done, aborted});
    end
    @(negedge clk);
    rst = 1'b0;
    ref_lfsr = 16'hACE1;
    num_test = 1; n_pkt = 9'd3; start = 1'b1;
    push_exp(3, 1'b0);
    @(negedge clk);
    start = 1'b0;
    n_run++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_first_start: busy %b expected 1", busy); end
    for (int c = 0; c < 15 && !sd; c++) begin
      @(negedge clk);
      if (aborted) n_pulse++;
      if (test_done) n_td++;
      if (pkt_valid && pkt_ready) begin
        n_hs++;
        n_run++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rst_seed_len: unexpected handshake len %0d", pkt_len);
        end else begin
          e = exp_q.pop_front();
          if (pkt_len !== e) begin n_fail++; $display("FAIL rst_seed_len: got %0d expected %0d", pkt_len, e); end
        end
      end
      if (suite_done) sd = 1;
    end
    n_run++;
    if (!sd || n_hs != 3 || n_td != 1 || n_pulse != 0) begin
      n_fail++; $display("FAIL rst_rerun: sd %0d hs %0d done %0d aborted %0d expected 1 3 1 0", sd, n_hs, n_td, n_pulse);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_random_stall();
    test_basic_suite();
    test_zero_tests();
    test_clamp();
    test_start_abort_idle();
    test_abort();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
